key_event: RTL and testbench

- Consumes the debounced, same-clock key level from the key debounce stage.
- Turns it into single-cycle event pulses: press, release, click, long-press, auto-repeat and, optionally, double-click.
- Feeds menu/UI control logic, so that logic never has to time key levels itself.
- Pure timing/FSM block; no synchroniser, because the input is already in the sys_clk domain.

---
 rtl/key_event_pkg.sv | 11 +
 rtl/key_event_if.sv | 25 ++
 rtl/key_edge_detect.sv | 26 ++
 rtl/key_event.sv | 146 ++++++++++++++
 tb/tb_key_event.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/key_event_pkg.sv
// key_event_pkg: shared state encoding and default timing constants for key_event
package key_event_pkg;

    typedef enum logic [2:0] {IDLE, PRESSED, HELD, LOCKED, WAIT2} state_t;

    localparam int DEF_CNT_W         = 26;
    localparam int DEF_LONG_CYCLES   = 50000000;
    localparam int DEF_REPEAT_CYCLES = 10000000;
    localparam int DEF_DOUBLE_CYCLES = 15000000;

endpackage

// File: rtl/key_event_if.sv
// key_event_if: key level in, event pulses out; slave is the key_event side
interface key_event_if;

    logic key_value;
    logic key_down;
    logic press_pulse;
    logic release_pulse;
    logic click_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic double_pulse;

    modport slave (
        input  key_value,
        output key_down, press_pulse, release_pulse, click_pulse,
               long_pulse, repeat_pulse, double_pulse
    );

    modport master (
        output key_value,
        input  key_down, press_pulse, release_pulse, click_pulse,
               long_pulse, repeat_pulse, double_pulse
    );

endinterface

// File: rtl/key_edge_detect.sv
// key_edge_detect: folds key polarity, registers the level and flags press/release edges
module key_edge_detect #(
    parameter int ACTIVE_LOW = 1
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_value,
    output logic level,
    output logic pressed,
    output logic rise,
    output logic fall
);

    logic pressed_d;

    assign level = key_value ^ (ACTIVE_LOW != 0);
    assign rise  = pressed & ~pressed_d;
    assign fall  = ~pressed & pressed_d;

    // Level pipeline; reset preloads both stages so a key held through reset makes no edge
    always_ff @(posedge sys_clk) begin
        pressed   <= level;
        pressed_d <= sys_rst ? level : pressed;
    end

endmodule

// File: rtl/key_event.sv
// key_event: turns a debounced key level into press/release/click/long/repeat/double pulses; macro KEY_DOUBLE_CLICK_EN enables double-click
module key_event
    import key_event_pkg::*;
#(
    parameter int ACTIVE_LOW    = 1,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int DOUBLE_CYCLES = DEF_DOUBLE_CYCLES
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    key_event_if.slave  kif
);

    localparam logic [CNT_W-1:0] LONG_T = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_T  = CNT_W'(REPEAT_CYCLES - 1);

    logic level, pressed, rise, fall;
    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic press_n, release_n, click_n, long_n, repeat_n, double_n;

`ifdef KEY_DOUBLE_CLICK_EN
    localparam logic [CNT_W-1:0] DBL_T = CNT_W'(DOUBLE_CYCLES - 1);
    // Marks a press that is already the second half of a double-click
    logic dbl, dbl_n;
`endif

    key_edge_detect #(.ACTIVE_LOW(ACTIVE_LOW)) u_edge (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .key_value (kif.key_value),
        .level     (level),
        .pressed   (pressed),
        .rise      (rise),
        .fall      (fall)
    );

    // Next state, counter and pulse decode; a release always beats a terminal count
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + CNT_W'(1);
        press_n   = 1'b0;
        release_n = 1'b0;
        click_n   = 1'b0;
        long_n    = 1'b0;
        repeat_n  = 1'b0;
        double_n  = 1'b0;
`ifdef KEY_DOUBLE_CLICK_EN
        dbl_n     = dbl;
`endif
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (rise) begin
                    press_n = 1'b1;
                    state_n = PRESSED;
                end
            end
            PRESSED: begin
                if (fall) begin
                    release_n = 1'b1;
                    cnt_n     = '0;
                    state_n   = IDLE;
`ifdef KEY_DOUBLE_CLICK_EN
                    dbl_n     = 1'b0;
                    if (cnt != LONG_T && !dbl) state_n = WAIT2;
`else
                    click_n   = cnt != LONG_T;
`endif
                end else if (cnt == LONG_T) begin
                    long_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = HELD;
                end
            end
            HELD: begin
                if (fall) begin
                    release_n = 1'b1;
                    cnt_n     = '0;
                    state_n   = IDLE;
                end else if (cnt == REP_T) begin
                    repeat_n = 1'b1;
                    cnt_n    = '0;
                end
            end
            LOCKED: begin
                cnt_n   = '0;
                state_n = pressed ? LOCKED : IDLE;
            end
`ifdef KEY_DOUBLE_CLICK_EN
            WAIT2: begin
                if (rise) begin
                    press_n  = 1'b1;
                    double_n = 1'b1;
                    dbl_n    = 1'b1;
                    cnt_n    = '0;
                    state_n  = PRESSED;
                end else if (cnt == DBL_T) begin
                    click_n = 1'b1;
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            end
`endif
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    // State, counter and registered outputs; reset locks out a key that is already held
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state              <= level ? LOCKED : IDLE;
            cnt                <= '0;
            kif.key_down       <= 1'b0;
            kif.press_pulse    <= 1'b0;
            kif.release_pulse  <= 1'b0;
            kif.click_pulse    <= 1'b0;
            kif.long_pulse     <= 1'b0;
            kif.repeat_pulse   <= 1'b0;
            kif.double_pulse   <= 1'b0;
        end else begin
            state              <= state_n;
            cnt                <= cnt_n;
            kif.key_down       <= pressed;
            kif.press_pulse    <= press_n;
            kif.release_pulse  <= release_n;
            kif.click_pulse    <= click_n;
            kif.long_pulse     <= long_n;
            kif.repeat_pulse   <= repeat_n;
            kif.double_pulse   <= double_n;
        end
    end

`ifdef KEY_DOUBLE_CLICK_EN
    // Double-click marker register
    always_ff @(posedge sys_clk) begin
        dbl <= sys_rst ? 1'b0 : dbl_n;
    end
`endif

endmodule

// File: tb/tb_key_event.sv
// tb_key_event: scoreboard bench for key_event; expected pulses are queued per cycle and compared every cycle
module tb_key_event;

    localparam int LONG = 20;
    localparam int REP  = 5;
    localparam int DBL  = 8;

    localparam logic [5:0] P  = 6'd1;
    localparam logic [5:0] R  = 6'd2;
    localparam logic [5:0] C  = 6'd4;
    localparam logic [5:0] L  = 6'd8;
    localparam logic [5:0] RP = 6'd16;
    localparam logic [5:0] D  = 6'd32;

    typedef struct {
        int         t;
        logic [5:0] m;
    } exp_t;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t q[$];

    key_event_if kif();

    key_event #(
        .ACTIVE_LOW    (1),
        .CNT_W         (26),
        .LONG_CYCLES   (LONG),
        .REPEAT_CYCLES (REP),
        .DOUBLE_CYCLES (DBL)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .kif     (kif.slave)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, act, exp, cyc);
        end
    endtask

    task automatic push(input int t, input logic [5:0] m);
        q.push_back('{t, m});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [5:0] obs_pulses();
        return {kif.double_pulse, kif.repeat_pulse, kif.long_pulse,
                kif.click_pulse, kif.release_pulse, kif.press_pulse};
    endfunction

    // Pop every expectation due this cycle and compare against the observed pulse vector
    always @(negedge sys_clk) begin
        logic [5:0] e;
        e = '0;
        while (q.size() > 0 && q[0].t <= cyc) begin
            if (q[0].t < cyc) check("stale_exp", cyc, q[0].t);
            else e = e | q[0].m;
            void'(q.pop_front());
        end
        if (obs_pulses() != 6'd0 || e != 6'd0) check("pulses", {26'd0, obs_pulses()}, {26'd0, e});
    end

    // Single press of n cycles; release is seen n+2 edges after the drive point
    task automatic press_for(input int n);
        int t, r;
        t = cyc;
        r = t + n + 2;
        push(t + 2, P);
        if (n < LONG) begin
`ifdef KEY_DOUBLE_CLICK_EN
            push(r, R);
            push(r + DBL, C);
`else
            push(r, R | C);
`endif
        end else begin
            if (n > LONG) push(t + 2 + LONG, L);
            for (int k = t + 2 + LONG + REP; k < r; k += REP) push(k, RP);
            push(r, R);
        end
        kif.key_value = 1'b0;
        step(n);
        check("key_down_held", kif.key_down, 1);
        kif.key_value = 1'b1;
        step(DBL + 6);
        check("key_down_rel", kif.key_down, 0);
    endtask

    // Press 3, gap g, press 3
    task automatic two_press(input int g);
        int t, r1, p2, r2;
        t  = cyc;
        r1 = t + 5;
        p2 = t + 3 + g + 2;
        r2 = p2 + 3;
        push(t + 2, P);
`ifdef KEY_DOUBLE_CLICK_EN
        push(r1, R);
        if (p2 <= r1 + DBL) begin
            push(p2, P | D);
            push(r2, R);
        end else begin
            push(r1 + DBL, C);
            push(p2, P);
            push(r2, R);
            push(r2 + DBL, C);
        end
`else
        push(r1, R | C);
        push(p2, P);
        push(r2, R | C);
`endif
        kif.key_value = 1'b0;
        step(3);
        kif.key_value = 1'b1;
        step(g);
        kif.key_value = 1'b0;
        step(3);
        kif.key_value = 1'b1;
        step(DBL + 6);
    endtask

    initial begin
        int t;
        kif.key_value = 1'b1;
        sys_rst = 1'b1;
        step(3);
        check("rst_key_down", kif.key_down, 0);
        check("rst_pulses", {26'd0, obs_pulses()}, 0);
        sys_rst = 1'b0;
        step(3);
        check("idle_key_down", kif.key_down, 0);

        press_for(10);
        press_for(19);
        press_for(LONG);
        press_for(41);
        press_for(LONG + REP);

        t = cyc;
        push(t + 2, P);
        kif.key_value = 1'b0;
        step(5);
        sys_rst = 1'b1;
        step(3);
        check("midhold_rst_key_down", kif.key_down, 0);
        sys_rst = 1'b0;
        step(5);
        check("locked_key_down", kif.key_down, 1);
        kif.key_value = 1'b1;
        step(5);
        press_for(4);

        two_press(5);
        two_press(12);
        two_press(8);
        two_press(9);

        step(5);
        check("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
